// File: rtl/flip_flops_pkg.sv
// Shared definitions for the flip_flops slice: default reset value,
// SR/JK control-pair encoding and the common next-state helper.
package flip_flops_pkg;

    // Value every flop loads on reset unless overridden by RST_VAL.
    localparam logic RST_VAL_DEFAULT = 1'b0;

    // Two-bit control pair: {S,R} for the SR flop, {J,K} for the JK flop.
    // Code 2'b11 toggles on a JK flop and is the invalid pair on an SR flop.
    typedef enum logic [1:0] {
        CTL_HOLD = 2'b00,
        CTL_CLR  = 2'b01,
        CTL_SET  = 2'b10,
        CTL_TGL  = 2'b11
    } ctl_e;

    // Next state for a control-pair flop. When tgl_is_clr is set the
    // 2'b11 code resolves to clear, giving the SR flop a deterministic
    // reset-dominant behaviour instead of an undefined state.
    function automatic logic ctl_next(
        input ctl_e ctl,
        input logic q,
        input logic tgl_is_clr
    );
        logic nq;
        nq = q;
        case (ctl)
            CTL_HOLD: nq = q;
            CTL_CLR:  nq = 1'b0;
            CTL_SET:  nq = 1'b1;
            CTL_TGL:  nq = tgl_is_clr ? 1'b0 : ~q;
            default:  nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/flip_flops_ff_cell.sv
// ff_cell: one storage bit with a next-state input and synchronous,
// active-low reset. Ports: clk, rst (active-low), d_i (next state), q_o.
module ff_cell
    import flip_flops_pkg::*;
#(
    parameter logic RST_VAL = RST_VAL_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/flip_flops.sv
// flip_flops: four independent registered flops (SR, JK, D, T).
// Inputs S,R,J,K,Din,T,clk,rst(active-low, sync); outputs Q_SR,Q_JK,Q_D,Q_T.
module flip_flops
    import flip_flops_pkg::*;
#(
    parameter logic RST_VAL = RST_VAL_DEFAULT
) (
    input  logic S,
    input  logic R,
    input  logic J,
    input  logic K,
    input  logic Din,
    input  logic T,
    input  logic clk,
    input  logic rst,
    output logic Q_SR,
    output logic Q_JK,
    output logic Q_D,
    output logic Q_T
);

    logic sr_d;
    logic jk_d;
    logic d_d;
    logic t_d;

    // Each next-state function reads only its own inputs and its own
    // output, so an X on one flop's inputs cannot reach another flop.
    always_comb begin
        sr_d = ctl_next(ctl_e'({S, R}), Q_SR, 1'b1);
        jk_d = ctl_next(ctl_e'({J, K}), Q_JK, 1'b0);
        d_d  = Din;
        t_d  = T ? ~Q_T : Q_T;
    end

    ff_cell #(.RST_VAL(RST_VAL)) u_sr (
        .clk (clk),
        .rst (rst),
        .d_i (sr_d),
        .q_o (Q_SR)
    );

    ff_cell #(.RST_VAL(RST_VAL)) u_jk (
        .clk (clk),
        .rst (rst),
        .d_i (jk_d),
        .q_o (Q_JK)
    );

    ff_cell #(.RST_VAL(RST_VAL)) u_d (
        .clk (clk),
        .rst (rst),
        .d_i (d_d),
        .q_o (Q_D)
    );

    ff_cell #(.RST_VAL(RST_VAL)) u_t (
        .clk (clk),
        .rst (rst),
        .d_i (t_d),
        .q_o (Q_T)
    );

endmodule

// File: tb/tb_flip_flops.sv
// Scoreboard bench for flip_flops: driver queues hand-computed
// expectations, monitor compares {Q_SR,Q_JK,Q_D,Q_T} after each edge.
module tb_flip_flops;

    logic S, R, J, K, Din, T;
    logic clk;
    logic rst;
    logic Q_SR, Q_JK, Q_D, Q_T;

    typedef struct {
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    flip_flops dut (
        .S    (S),
        .R    (R),
        .J    (J),
        .K    (K),
        .Din  (Din),
        .T    (T),
        .clk  (clk),
        .rst  (rst),
        .Q_SR (Q_SR),
        .Q_JK (Q_JK),
        .Q_D  (Q_D),
        .Q_T  (Q_T)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: each rising edge the DUT presents a new state; one queued
    // expectation belongs to each edge for which the driver issued a vector.
    initial begin
        exp_t       e;
        logic [3:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {Q_SR, Q_JK, Q_D, Q_T};
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got SR/JK/D/T=%b expected %b",
                             e.name, act, e.exp);
                end
            end
        end
    end

    // Drive one vector on the falling edge and queue the state expected
    // after the following rising edge. pulse drops rst briefly mid-cycle.
    task automatic step(
        input logic       rst_v,
        input logic       s_v,
        input logic       r_v,
        input logic       j_v,
        input logic       k_v,
        input logic       d_v,
        input logic       t_v,
        input logic [3:0] exp,
        input string      nm,
        input bit         pulse
    );
        exp_t e;
        @(negedge clk);
        rst = rst_v;
        S   = s_v;
        R   = r_v;
        J   = j_v;
        K   = k_v;
        Din = d_v;
        T   = t_v;
        e.exp  = exp;
        e.name = nm;
        sb.push_back(e);
        if (pulse) begin
            #1 rst = 1'b0;
            #2 rst = 1'b1;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        {S, R, J, K, Din, T} = 6'b0;

        // Reset with random data: inputs must be overridden.
        step(0, 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom),
             4'b0000, "reset_edge1", 0);
        step(0, 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom),
             4'b0000, "reset_edge2", 0);
        step(1, 0, 0, 0, 0, 0, 0, 4'b0000, "release_hold", 0);

        // Set / clear.
        step(1, 1, 0, 1, 0, 1, 1, 4'b1111, "set", 0);
        step(1, 0, 1, 0, 1, 0, 0, 4'b0001, "clear", 0);

        // Toggle three edges: JK 1,0,1 and T 0,1,0.
        step(1, 0, 0, 1, 1, 1, 1, 4'b0110, "toggle1", 0);
        step(1, 0, 0, 1, 1, 1, 1, 4'b0011, "toggle2", 0);
        step(1, 0, 0, 1, 1, 1, 1, 4'b0110, "toggle3", 0);

        // SR invalid pair resolves to clear.
        step(1, 1, 0, 0, 0, 0, 0, 4'b1100, "sr_set", 0);
        step(1, 1, 1, 0, 0, 0, 0, 4'b0100, "sr_both", 0);

        // Mid-cycle rst pulse must not disturb a fully set state.
        step(1, 1, 0, 1, 0, 1, 1, 4'b1111, "preset", 0);
        step(1, 0, 0, 0, 0, 1, 0, 4'b1111, "rst_glitch", 1);

        // Reset at an edge while toggling overrides everything.
        step(0, 1, 0, 1, 1, 1, 1, 4'b0000, "rst_mid_tgl", 0);

        // Immediate resume after release.
        step(1, 0, 0, 1, 1, 0, 1, 4'b0101, "resume", 0);
        step(1, 0, 1, 1, 1, 1, 1, 4'b0010, "resume2", 0);

        // Drain the scoreboard within a bounded number of edges.
        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flip_flops.md
FLIP_FLOPS -- requirements
Module: flip_flops

Interface
REQ-001 Parameter RST_VAL, default 1'b0: value loaded into every flop output on reset.
REQ-002 Port order SHALL be S, R, J, K, Din, T, clk, rst, Q_SR, Q_JK, Q_D, Q_T, because instantiations connect ports by position.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset: synchronous, active-low; sampled only at the clk rising edge.
REQ-005 S  input  1  set input of the SR flop.
REQ-006 R  input  1  reset input of the SR flop.
REQ-007 J  input  1  J input of the JK flop.
REQ-008 K  input  1  K input of the JK flop.
REQ-009 Din  input  1  data input of the D flop.
REQ-010 T  input  1  toggle input of the T flop.
REQ-011 Q_SR  output  1  registered SR flop state.
REQ-012 Q_JK  output  1  registered JK flop state.
REQ-013 Q_D  output  1  registered D flop state.
REQ-014 Q_T  output  1  registered T flop state.

Function
REQ-015 All four outputs SHALL be registered, with no combinational path from any input to any output.
REQ-016 The four flops SHALL be independent; no flop's input or state affects another flop.
REQ-017 The SR flop SHALL update on each clk rising edge as follows:
- S=0, R=0 -> hold.
- S=1, R=0 -> 1.
- S=0, R=1 -> 0.
- S=1, R=1 -> 0 (reset-dominant; deterministic, never X).
REQ-018 The JK flop SHALL update on each clk rising edge as follows:
- J=0, K=0 -> hold.
- J=1, K=0 -> 1.
- J=0, K=1 -> 0.
- J=1, K=1 -> toggle.
REQ-019 The D flop SHALL update on each clk rising edge so that Q_D takes the value of Din.
REQ-020 The T flop SHALL update on each clk rising edge as follows:
- T=1 -> toggle.
- T=0 -> hold.
REQ-021 Latency SHALL be exactly one clock: an input sampled at edge n is visible on the output after edge n.
REQ-022 X or Z on any data input SHALL NOT corrupt the other flops.

Reset
REQ-023 When rst=0 at a clk rising edge, all four outputs SHALL load RST_VAL, overriding every data input.
REQ-024 Reset SHALL NOT act asynchronously: a rst pulse that falls and rises between two clk rising edges has no effect.
REQ-025 After power-up, outputs MAY be X until the first clk rising edge with rst=0.
REQ-026 Deasserting reset (rst=1) SHALL resume normal function at the very next clk rising edge.

Structure
REQ-027 A shared package SHALL hold the default reset value constant and a 2-bit encoding for SR/JK control pairs, covering the HOLD, SET, CLR and TGL/INVALID codes.
REQ-028 A single generic sub-module ff_cell SHALL provide one clk/rst-synchronous storage bit with a next-state input.
REQ-029 flip_flops SHALL instantiate ff_cell four times, each driven by its own next-state logic.

Verification
REQ-030 Reset test: hold rst=0 for 2 edges with random data inputs -> all Q = 0; then release rst=1 with all inputs 0 -> all Q stay 0.
REQ-031 Set test: S=1, R=0, J=1, K=0, Din=1, T=1 for 1 edge after reset -> Q_SR=1, Q_JK=1, Q_D=1, Q_T=1.
REQ-032 Clear test: S=0, R=1, J=0, K=1, Din=0, T=0 on the next edge -> Q_SR=0, Q_JK=0, Q_D=0, Q_T=1 (T held).
REQ-033 Toggle test: S=0, R=0, J=1, K=1, Din=1, T=1 for 3 edges:
- Q_JK: 1, 0, 1.
- Q_T: 0, 1, 0.
- Q_SR holds 0.
- Q_D=1.
REQ-034 Corner test: S=R=1 -> Q_SR=0.
REQ-035 Sync-reset test: rst pulsed low mid-cycle, back high before the edge -> no change.
REQ-036 Reset-mid-toggle test: rst=0 at an edge while J=K=1 and T=1 -> all Q=0.
